// File: rtl/mem_lib_pkg.sv
// mem_lib_pkg: shared constants, scrub FSM type and sizing helper for the memory library
package mem_lib_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  typedef enum logic {IDLE, CLEAR} scrub_state_t;
  function automatic int calc_nbe(input int width, input int byte_w);
    return width / byte_w;
  endfunction
endpackage

// File: rtl/mem_scrub_ctrl.sv
// mem_scrub_ctrl: sequential clear engine walking every word once and flagging busy meanwhile
module mem_scrub_ctrl
  import mem_lib_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic [AW-1:0] scrub_addr
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  scrub_state_t state, state_n;
  logic [AW-1:0] cnt, cnt_n;
  // state and counter; reset always restarts the scrub from word 0
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  // clr is only taken from IDLE; the scrub leaves CLEAR after clearing the last word
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    state_n = (state == IDLE) ? (clr ? CLEAR : IDLE) : (cnt == LAST ? IDLE : CLEAR);
    cnt_n = (state == CLEAR && cnt != LAST) ? cnt + 1'b1 : '0;
  end
  assign busy = (state == CLEAR);
  assign scrub_addr = cnt;
endmodule

// File: rtl/dp_ram_param.sv
// dp_ram_param: parametrised 1W/1R synchronous RAM with byte enables, scrub and optional output stage
module dp_ram_param
  import mem_lib_pkg::*;
#(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 16,
  parameter int ADDR_SIZE = 4,
  parameter int BYTE_W = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0,
  localparam int NBE = calc_nbe(RAM_WIDTH, BYTE_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_enb,
  input  logic [NBE-1:0]       wr_be,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0] data_in,
  input  logic                 rd_enb,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [RAM_WIDTH-1:0] data_out,
  output logic                 rd_valid,
  output logic                 busy
);
  localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE + 1)'(RAM_DEPTH);
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] merged, rd_word, d1, d2;
  logic [ADDR_SIZE-1:0] scrub_addr;
  logic we, re, rd_ok, v1, v2;

  mem_scrub_ctrl #(.DEPTH(RAM_DEPTH), .AW(ADDR_SIZE)) u_scrub (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .busy(busy),
    .scrub_addr(scrub_addr)
  );

  assign we = wr_enb && !busy && ({1'b0, wr_addr} < DEPTH_L);
  assign re = rd_enb && !busy;
  assign rd_ok = {1'b0, rd_addr} < DEPTH_L;

  // post-write word: enabled lanes from data_in, the rest from the stored word
  always_comb begin
    merged = mem[wr_addr];
    for (int i = 0; i < NBE; i++)
      if (wr_be[i]) merged[i*BYTE_W +: BYTE_W] = data_in[i*BYTE_W +: BYTE_W];
  end

  assign rd_word = !rd_ok ? '0 :
                   (RDW_MODE == RDW_NEW && we && rd_addr == wr_addr) ? merged : mem[rd_addr];

  // array update; the scrub owns the array whenever busy so user writes never collide
  always_ff @(posedge clk)
    if (busy) mem[scrub_addr] <= '0;
    else if (we) mem[wr_addr] <= merged;

  // read register plus optional pipeline stage; data holds between reads
  always_ff @(posedge clk)
    if (rst) begin
      d1 <= '0;
      v1 <= 1'b0;
      d2 <= '0;
      v2 <= 1'b0;
    end else begin
      v1 <= re;
      d1 <= re ? rd_word : d1;
      v2 <= v1;
      d2 <= v1 ? d1 : d2;
    end

  assign data_out = (OUT_REG != 0) ? d2 : d1;
  assign rd_valid = (OUT_REG != 0) ? v2 : v1;
endmodule

// File: tb/tb_dp_ram_param.sv
// tb_dp_ram_param: scoreboard bench over four RAM configurations sharing one stimulus bus
module tb_dp_ram_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, clr = 1'b0, wr_enb = 1'b0, rd_enb = 1'b0;
  logic [3:0] sel = 4'hF, wr_be = 4'h0, wr_addr = 4'h0, rd_addr = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] dout [4];
  logic [3:0] rv, bsy;
  logic [7:0] d0, d1, d3;
  logic [31:0] d2;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int k;
    logic [31:0] data;
    int due;
    int id;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int nid = 0;

  // u0: 8x16, old-data RDW, no output stage
  dp_ram_param #(.RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_SIZE(4), .RDW_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst & sel[0]), .clr(clr & sel[0]), .wr_enb(wr_enb & sel[0]), .wr_be(wr_be[0:0]),
    .wr_addr(wr_addr), .data_in(data_in[7:0]), .rd_enb(rd_enb & sel[0]), .rd_addr(rd_addr),
    .data_out(d0), .rd_valid(rv[0]), .busy(bsy[0]));
  // u1: 8x16, new-data RDW
  dp_ram_param #(.RAM_WIDTH(8), .RAM_DEPTH(16), .ADDR_SIZE(4), .RDW_MODE(1), .OUT_REG(0)) u1 (
    .clk(clk), .rst(rst & sel[1]), .clr(clr & sel[1]), .wr_enb(wr_enb & sel[1]), .wr_be(wr_be[0:0]),
    .wr_addr(wr_addr), .data_in(data_in[7:0]), .rd_enb(rd_enb & sel[1]), .rd_addr(rd_addr),
    .data_out(d1), .rd_valid(rv[1]), .busy(bsy[1]));
  // u2: 32x16 with byte lanes and an output stage
  dp_ram_param #(.RAM_WIDTH(32), .RAM_DEPTH(16), .ADDR_SIZE(4), .RDW_MODE(0), .OUT_REG(1)) u2 (
    .clk(clk), .rst(rst & sel[2]), .clr(clr & sel[2]), .wr_enb(wr_enb & sel[2]), .wr_be(wr_be),
    .wr_addr(wr_addr), .data_in(data_in), .rd_enb(rd_enb & sel[2]), .rd_addr(rd_addr),
    .data_out(d2), .rd_valid(rv[2]), .busy(bsy[2]));
  // u3: 8x12 in a 4-bit address space
  dp_ram_param #(.RAM_WIDTH(8), .RAM_DEPTH(12), .ADDR_SIZE(4), .RDW_MODE(0), .OUT_REG(0)) u3 (
    .clk(clk), .rst(rst & sel[3]), .clr(clr & sel[3]), .wr_enb(wr_enb & sel[3]), .wr_be(wr_be[0:0]),
    .wr_addr(wr_addr), .data_in(data_in[7:0]), .rd_enb(rd_enb & sel[3]), .rd_addr(rd_addr),
    .data_out(d3), .rd_valid(rv[3]), .busy(bsy[3]));

  assign dout[0] = {24'h0, d0};
  assign dout[1] = {24'h0, d1};
  assign dout[2] = d2;
  assign dout[3] = {24'h0, d3};

  // monitor: every rd_valid pops the oldest expectation and checks data, owner and arrival cycle
  always @(negedge clk)
    for (int k = 0; k < 4; k++)
      if (rv[k]) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid dut%0d got=%h cyc=%0d", k, dout[k], cyc);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.k != k || dout[k] !== mon_e.data || cyc != mon_e.due) begin
            errors++;
            $display("FAIL read#%0d dut%0d got=%h@%0d want dut%0d %h@%0d",
                     mon_e.id, k, dout[k], cyc, mon_e.k, mon_e.data, mon_e.due);
          end
        end
      end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_wr(input int k, input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    sel = 4'(1 << k);
    wr_enb = 1'b1;
    wr_addr = a;
    data_in = d;
    wr_be = be;
    tick();
    wr_enb = 1'b0;
  endtask

  task automatic push(input int k, input logic [31:0] e);
    q.push_back('{k: k, data: e, due: cyc + 1 + (k == 2 ? 1 : 0), id: nid});
    nid++;
  endtask

  task automatic do_rd(input int k, input logic [3:0] a, input logic [31:0] e);
    sel = 4'(1 << k);
    rd_enb = 1'b1;
    rd_addr = a;
    push(k, e);
    tick();
    rd_enb = 1'b0;
  endtask

  task automatic do_rdw(input int k, input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
    sel = 4'(1 << k);
    wr_enb = 1'b1;
    wr_addr = a;
    data_in = d;
    wr_be = 4'hF;
    rd_enb = 1'b1;
    rd_addr = a;
    push(k, e);
    tick();
    wr_enb = 1'b0;
    rd_enb = 1'b0;
  endtask

  task automatic count_busy(input int k, output int n);
    n = 0;
    for (int i = 0; i < 40 && bsy[k]; i++) begin
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    tick();
    sel = 4'hF;
    rst = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_busy%0d", k), 32'(bsy[k]), 32'h1);
      chk($sformatf("reset_valid%0d", k), 32'(rv[k]), 32'h0);
      chk($sformatf("reset_dout%0d", k), dout[k], 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 40 && bsy != 4'h0; i++) tick();
    chk("initial_scrub_done", 32'(bsy), 32'h0);

    do_wr(0, 4'd2, 32'h77, 4'h1);
    do_wr(0, 4'd7, 32'h12, 4'h1);
    do_rd(0, 4'd2, 32'h77);
    do_rd(0, 4'd7, 32'h12);
    tick();
    tick();
    chk("dout_hold", dout[0], 32'h12);
    chk("valid_pulse", 32'(rv[0]), 32'h0);
    sel = 4'h1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(0, n);
    chk("busy_after_rst", 32'(n), 32'd16);
    for (int a = 0; a < 16; a++) do_rd(0, 4'(a), 32'h0);

    do_wr(0, 4'd3, 32'h5A, 4'h1);
    do_rdw(0, 4'd3, 32'hC3, 32'h5A);
    do_rd(0, 4'd3, 32'hC3);
    do_wr(1, 4'd3, 32'h5A, 4'h1);
    do_rdw(1, 4'd3, 32'hC3, 32'hC3);
    do_rd(1, 4'd3, 32'hC3);
    sel = 4'h1;
    wr_enb = 1'b1;
    wr_addr = 4'd4;
    data_in = 32'h99;
    wr_be = 4'h1;
    rd_enb = 1'b1;
    rd_addr = 4'd3;
    push(0, 32'hC3);
    tick();
    wr_enb = 1'b0;
    rd_enb = 1'b0;
    do_rd(0, 4'd4, 32'h99);

    do_wr(0, 4'd5, 32'h66, 4'h1);
    sel = 4'h1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("busy_after_clr", 32'(bsy[0]), 32'h1);
    for (int i = 0; i < 9; i++) begin
      wr_enb = 1'b1;
      wr_addr = 4'd15;
      data_in = 32'hEE;
      wr_be = 4'h1;
      rd_enb = 1'b1;
      rd_addr = 4'd4;
      clr = 1'b1;
      tick();
    end
    wr_enb = 1'b0;
    rd_enb = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_busy(0, n);
    chk("busy_after_mid_rst", 32'(n), 32'd16);
    do_rd(0, 4'd15, 32'h0);
    do_rd(0, 4'd5, 32'h0);
    do_rd(0, 4'd4, 32'h0);

    do_wr(2, 4'd1, 32'h11223344, 4'hF);
    do_wr(2, 4'd1, 32'hAABBCCDD, 4'b0101);
    do_rd(2, 4'd1, 32'h11BB33DD);
    do_wr(2, 4'd1, 32'hFFFFFFFF, 4'h0);
    do_rd(2, 4'd1, 32'h11BB33DD);
    for (int a = 0; a < 4; a++) do_wr(2, 4'(a), 32'hA0A0_0000 + 32'(a), 4'hF);
    for (int a = 0; a < 4; a++) do_rd(2, 4'(a), 32'hA0A0_0000 + 32'(a));

    for (int a = 0; a < 12; a++) do_wr(3, 4'(a), 32'h10 + 32'(a), 4'h1);
    do_wr(3, 4'd13, 32'hFF, 4'h1);
    do_rd(3, 4'd13, 32'h0);
    for (int a = 0; a < 12; a++) do_rd(3, 4'(a), 32'h10 + 32'(a));

    for (int i = 0; i < 4; i++) tick();
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
